// File: rtl/lse_div_pkg.sv
// Shared types and constants for the log-space divider: lane mode,
// special-value encodings and the per-result exception flag bundle.
package lse_div_pkg;

    typedef enum logic [0:0] {
        LSE_MODE_24 = 1'b0,
        LSE_MODE_6  = 1'b1
    } lse_mode_e;

    localparam logic [23:0]       LSE_NEG_INF_24 = 24'h800000;
    localparam logic [23:0]       LSE_MAX_24     = 24'h7FFFFF;
    localparam logic [5:0]        LSE_NEG_INF_6  = 6'd16;
    localparam logic signed [4:0] LSE_MAX_MAG_6  = 5'sd15;

    localparam int LSE_LANES  = 4;
    localparam int LSE_LANE_W = 6;

    typedef struct packed {
        logic dz;
        logic ovf;
        logic unf;
    } lse_flags_t;

    // Any non-zero PE mode selects the packed 6-bit lanes.
    function automatic lse_mode_e lse_decode_mode(input logic [1:0] pe_mode);
        return (pe_mode == 2'd0) ? LSE_MODE_24 : LSE_MODE_6;
    endfunction

endpackage

// File: rtl/lse_sub_sat.sv
// One lane of log-space subtraction: -inf handling, one-bit-wider
// difference and symmetric saturation to [-MAX, MAX].
module lse_sub_sat
    import lse_div_pkg::*;
#(
    parameter int             W       = 24,
    parameter logic [W-1:0]   NEG_INF = {1'b1, {(W-1){1'b0}}},
    parameter logic [W-1:0]   MAX     = {1'b0, {(W-1){1'b1}}}
) (
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    output logic [W-1:0] result,
    output lse_flags_t   flags
);

    localparam logic signed [W:0] D_MAX = $signed({1'b0, MAX});
    localparam logic signed [W:0] D_MIN = -D_MAX;

    logic              a_inf;
    logic              b_inf;
    logic signed [W:0] diff;

    assign a_inf = (operand_a == NEG_INF);
    assign b_inf = (operand_b == NEG_INF);
    assign diff  = $signed({operand_a[W-1], operand_a}) - $signed({operand_b[W-1], operand_b});

    // Rule order matters: a dividend of -inf dominates even a -inf divisor.
    always_comb begin
        result = diff[W-1:0];
        flags  = '0;
        if (a_inf) begin
            result   = NEG_INF;
            flags.dz = b_inf;
        end else if (b_inf) begin
            result   = MAX;
            flags.dz = 1'b1;
        end else if (diff > D_MAX) begin
            result    = MAX;
            flags.ovf = 1'b1;
        end else if (diff < D_MIN) begin
            result    = NEG_INF;
            flags.unf = 1'b1;
        end
    end

endmodule

// File: rtl/lse_div.sv
// Two-stage pipelined log-space divider, one 24-bit lane or four 6-bit
// sign-magnitude lanes, with sticky status and an accepted-result counter.
module lse_div
    import lse_div_pkg::*;
#(
    parameter int p_width     = 24,
    parameter int p_cnt_width = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [p_width-1:0]     i_operand_a,
    input  logic [p_width-1:0]     i_operand_b,
    input  logic [1:0]             i_pe_mode,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [p_width-1:0]     o_quotient,
    output logic [2:0]             o_flags,
    input  logic                   i_clr,
    output logic [2:0]             o_status,
    output logic [p_cnt_width-1:0] o_op_count
);

    logic                   s1_valid_reg;
    logic [p_width-1:0]     s1_a_reg;
    logic [p_width-1:0]     s1_b_reg;
    lse_mode_e              s1_mode_reg;

    logic                   s2_valid_reg;
    logic [p_width-1:0]     s2_quotient_reg;
    logic [2:0]             s2_flags_reg;

    logic [2:0]             status_reg;
    logic [p_cnt_width-1:0] count_reg;

    logic                   s2_advance;
    logic                   s1_advance;
    logic                   handshake;

    logic [p_width-1:0]     wide_result;
    lse_flags_t             wide_flags;
    logic [p_width-1:0]     lane_word;
    lse_flags_t             lane_flags [LSE_LANES];
    lse_flags_t             lane_flags_or;

    logic [p_width-1:0]     quotient_next;
    lse_flags_t             flags_next;

    // No skid buffer: acceptance is combinational from downstream ready.
    assign s2_advance = !s2_valid_reg || i_ready;
    assign s1_advance = !s1_valid_reg || s2_advance;
    assign handshake  = s2_valid_reg && i_ready;

    assign o_ready    = s1_advance;
    assign o_valid    = s2_valid_reg;
    assign o_quotient = s2_quotient_reg;
    assign o_flags    = s2_flags_reg;
    assign o_status   = status_reg;
    assign o_op_count = count_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_mode_reg  <= LSE_MODE_24;
        end else if (s1_advance) begin
            s1_valid_reg <= i_valid;
            if (i_valid) begin
                s1_a_reg    <= i_operand_a;
                s1_b_reg    <= i_operand_b;
                s1_mode_reg <= lse_decode_mode(i_pe_mode);
            end
        end
    end

    lse_sub_sat #(
        .W       (p_width),
        .NEG_INF (LSE_NEG_INF_24),
        .MAX     (LSE_MAX_24)
    ) u_wide (
        .operand_a (s1_a_reg),
        .operand_b (s1_b_reg),
        .result    (wide_result),
        .flags     (wide_flags)
    );

    for (genvar gi = 0; gi < LSE_LANES; gi++) begin : g_lane
        logic       sign_a;
        logic       sign_b;
        logic [4:0] mag;

        assign sign_a = s1_a_reg[LSE_LANE_W*gi + 5];
        assign sign_b = s1_b_reg[LSE_LANE_W*gi + 5];

        lse_sub_sat #(
            .W       (5),
            .NEG_INF (LSE_NEG_INF_6[4:0]),
            .MAX     (LSE_MAX_MAG_6)
        ) u_lane (
            .operand_a (s1_a_reg[LSE_LANE_W*gi +: 5]),
            .operand_b (s1_b_reg[LSE_LANE_W*gi +: 5]),
            .result    (mag),
            .flags     (lane_flags[gi])
        );

        // -inf (from a -inf dividend or underflow) always carries a clear sign bit.
        assign lane_word[LSE_LANE_W*gi +: LSE_LANE_W] =
            (mag == LSE_NEG_INF_6[4:0]) ? LSE_NEG_INF_6 : {sign_a ^ sign_b, mag};
    end

    always_comb begin
        lane_flags_or = '0;
        for (int i = 0; i < LSE_LANES; i++) begin
            lane_flags_or.dz  = lane_flags_or.dz  | lane_flags[i].dz;
            lane_flags_or.ovf = lane_flags_or.ovf | lane_flags[i].ovf;
            lane_flags_or.unf = lane_flags_or.unf | lane_flags[i].unf;
        end
    end

    always_comb begin
        quotient_next = wide_result;
        flags_next    = wide_flags;
        if (s1_mode_reg == LSE_MODE_6) begin
            quotient_next = lane_word;
            flags_next    = lane_flags_or;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_reg    <= 1'b0;
            s2_quotient_reg <= '0;
            s2_flags_reg    <= '0;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_quotient_reg <= quotient_next;
                s2_flags_reg    <= flags_next;
            end
        end
    end

    // Clear beats a same-cycle handshake so software sees a clean status.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            status_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (handshake) begin
                count_reg <= count_reg + 1'b1;
            end
            if (i_clr) begin
                status_reg <= '0;
            end else if (handshake) begin
                status_reg <= status_reg | s2_flags_reg;
            end
        end
    end

endmodule

// File: tb/tb_lse_div.sv
// Scoreboard bench for lse_div: directed cases plus random traffic checked
// against an integer-arithmetic reference model.
module tb_lse_div;

    logic        clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_operand_a;
    logic [23:0] i_operand_b;
    logic [1:0]  i_pe_mode;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_quotient;
    logic [2:0]  o_flags;
    logic        i_clr;
    logic [2:0]  o_status;
    logic [15:0] o_op_count;

    logic        o_ready_n4;
    logic        o_valid_n4;
    logic [23:0] o_quotient_n4;
    logic [2:0]  o_flags_n4;
    logic [2:0]  o_status_n4;
    logic [3:0]  cnt4;

    lse_div #(.p_width(24), .p_cnt_width(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_pe_mode   (i_pe_mode),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_quotient  (o_quotient),
        .o_flags     (o_flags),
        .i_clr       (i_clr),
        .o_status    (o_status),
        .o_op_count  (o_op_count)
    );

    lse_div #(.p_width(24), .p_cnt_width(4)) dut_c4 (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready_n4),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_pe_mode   (i_pe_mode),
        .o_valid     (o_valid_n4),
        .i_ready     (i_ready),
        .o_quotient  (o_quotient_n4),
        .o_flags     (o_flags_n4),
        .i_clr       (i_clr),
        .o_status    (o_status_n4),
        .o_op_count  (cnt4)
    );

    typedef struct {
        logic [23:0] q;
        logic [2:0]  f;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          script_cyc = 0;
    bit          rand_clr = 0;
    bit          saw_ready_low = 0;
    bit          mon_en = 0;
    logic [15:0] m_count = '0;
    logic [2:0]  m_status = '0;
    int          txn = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: log(a/b) from the encoding rules using plain integers.
    function automatic logic [26:0] ref_div(input logic [23:0] a, input logic [23:0] b,
                                            input logic [1:0] m);
        logic [23:0] q;
        logic [2:0]  f;
        int          d;
        q = '0;
        f = '0;
        if (m == 2'd0) begin
            if (a == 24'h800000) begin
                q = 24'h800000;
                f[2] = (b == 24'h800000);
            end else if (b == 24'h800000) begin
                q = 24'h7FFFFF;
                f[2] = 1'b1;
            end else begin
                d = int'($signed(a)) - int'($signed(b));
                if (d > 8388607) begin
                    q = 24'h7FFFFF;
                    f[1] = 1'b1;
                end else if (d < -8388607) begin
                    q = 24'h800000;
                    f[0] = 1'b1;
                end else begin
                    q = d[23:0];
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [5:0] la, lb, lq;
                int ma, mb, dd;
                logic s;
                la = a[6*i +: 6];
                lb = b[6*i +: 6];
                ma = (la[4:0] >= 5'd16) ? int'(la[4:0]) - 32 : int'(la[4:0]);
                mb = (lb[4:0] >= 5'd16) ? int'(lb[4:0]) - 32 : int'(lb[4:0]);
                s  = la[5] ^ lb[5];
                if (ma == -16) begin
                    lq = 6'd16;
                    if (mb == -16) f[2] = 1'b1;
                end else if (mb == -16) begin
                    lq = {s, 5'd15};
                    f[2] = 1'b1;
                end else begin
                    dd = ma - mb;
                    if (dd > 15) begin
                        lq = {s, 5'd15};
                        f[1] = 1'b1;
                    end else if (dd < -15) begin
                        lq = 6'd16;
                        f[0] = 1'b1;
                    end else begin
                        lq = {s, dd[4:0]};
                    end
                end
                q[6*i +: 6] = lq;
            end
        end
        return {f, q};
    endfunction

    function automatic logic [23:0] rand_op(input logic [1:0] m);
        logic [23:0] v;
        int          k;
        v = 24'($urandom);
        k = $urandom_range(0, 9);
        if (m == 2'd0) begin
            case (k)
                0: v = 24'h800000;
                1: v = 24'h7FFFFF;
                2: v = 24'h800001;
                3: v = {{20{v[23]}}, v[3:0]};
                4: v = {2'b10, v[21:0]};
                5: v = {2'b01, v[21:0]};
                default: ;
            endcase
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) v[6*i +: 5] = 5'd16;
            end
        end
        return v;
    endfunction

    task automatic drive_cycle(input bit v, input logic [23:0] a, input logic [23:0] b,
                               input logic [1:0] m, input bit clr);
        @(negedge clk);
        i_valid     = v;
        i_operand_a = a;
        i_operand_b = b;
        i_pe_mode   = m;
        i_clr       = clr;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(0, 3) != 0);
            default: i_ready = !(script_cyc >= 3 && script_cyc <= 5);
        endcase
        script_cyc++;
        #1;
    endtask

    task automatic send_exp(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m,
                            input logic [23:0] q, input logic [2:0] f);
        int   w;
        bit   clr;
        exp_t e;
        w = 0;
        do begin
            clr = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
            drive_cycle(1'b1, a, b, m, clr);
            if (!o_ready) begin
                if (ready_mode == 2) saw_ready_low = 1'b1;
                w++;
            end
        end while (!o_ready && w < 100);
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1 within 100 cycles");
        end else begin
            e.q   = q;
            e.f   = f;
            e.acc = cyc + 1;
            e.lat = (ready_mode == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_rand(input logic [1:0] m);
        logic [23:0] a, b;
        logic [26:0] r;
        a = rand_op(m);
        b = rand_op(m);
        r = ref_div(a, b, m);
        send_exp(a, b, m, r[23:0], r[26:24]);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || o_valid) && w < 200) begin
            drive_cycle(1'b0, '0, '0, 2'd0, 1'b0);
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Monitor: samples mid-cycle and accounts for the edge that follows.
    initial begin
        exp_t        e;
        logic [23:0] prev_q;
        logic [2:0]  prev_f;
        logic [2:0]  ef;
        bit          prev_stall;
        prev_stall = 1'b0;
        prev_q = '0;
        prev_f = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("op_count", 32'(o_op_count), 32'(m_count));
                chk("op_count4", 32'(cnt4), 32'(m_count[3:0]));
                chk("status", 32'(o_status), 32'(m_status));
                if (prev_stall) begin
                    chk("stall_hold", {4'b0, o_valid, o_flags, o_quotient},
                        {4'b0, 1'b1, prev_f, prev_q});
                end
                if (!i_rst_n) begin
                    exp_q.delete();
                    m_count    = '0;
                    m_status   = '0;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = o_valid && !i_ready;
                    prev_q     = o_quotient;
                    prev_f     = o_flags;
                    if (o_valid && i_ready) begin
                        ef = '0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: got q=%06h expected none", o_quotient);
                        end else begin
                            e  = exp_q.pop_front();
                            ef = e.f;
                            chk("quotient", 32'(o_quotient), 32'(e.q));
                            chk("flags", 32'(o_flags), 32'(e.f));
                            if (e.lat) chk("latency", 32'(cyc + 1 - e.acc), 32'd2);
                            $display("txn %0d q=%06h f=%03b", txn, o_quotient, o_flags);
                            txn++;
                        end
                        m_count  = m_count + 16'd1;
                        m_status = m_status | ef;
                    end
                    if (i_clr) m_status = '0;
                end
            end
        end
    end

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_operand_a = '0;
        i_operand_b = '0;
        i_pe_mode   = '0;
        i_ready     = 1'b1;
        i_clr       = 1'b0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_quotient", 32'(o_quotient), 32'd0);
        chk("rst_flags", 32'(o_flags), 32'd0);
        chk("rst_status", 32'(o_status), 32'd0);
        chk("rst_count", 32'(o_op_count), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        mon_en = 1'b1;

        // 24-bit basic and edge cases, expected values worked by hand
        ready_mode = 0;
        send_exp(24'h000010, 24'h000004, 2'd0, 24'h00000C, 3'b000);
        send_exp(24'h000004, 24'h000010, 2'd0, 24'hFFFFF4, 3'b000);
        send_exp(24'h7FFFF0, 24'hFFFFF0, 2'd0, 24'h7FFFFF, 3'b010);
        send_exp(24'h800010, 24'h000020, 2'd0, 24'h800000, 3'b001);
        send_exp(24'h000005, 24'h800000, 2'd0, 24'h7FFFFF, 3'b100);
        send_exp(24'h800000, 24'h800000, 2'd0, 24'h800000, 3'b100);
        // 6-bit lanes {l3,l2,l1,l0}
        send_exp({6'b000011, 6'b001111, 6'b010000, 6'b000101},
                 {6'b010000, 6'b011111, 6'b000001, 6'b100011}, 2'd1,
                 {6'b001111, 6'b001111, 6'b010000, 6'b100010}, 3'b110);
        send_exp({6'b000000, 6'b000000, 6'b000000, 6'b010001},
                 {6'b000000, 6'b000000, 6'b000000, 6'b000001}, 2'd2,
                 {6'b000000, 6'b000000, 6'b000000, 6'b010000}, 3'b001);
        drain();

        // backpressure: six back-to-back pairs, i_ready low for cycles 3-5
        @(negedge clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        ready_mode    = 2;
        script_cyc    = 0;
        saw_ready_low = 1'b0;
        for (int i = 0; i < 6; i++) send_rand(2'($urandom_range(0, 3)));
        drain();
        chk("bp_ready_dropped", 32'(saw_ready_low), 32'd1);
        chk("bp_count", 32'(o_op_count), 32'd6);
        ready_mode = 0;

        // i_clr coinciding with a handshake wins over the OR-in
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b1);
        send_exp(24'h7FFFF0, 24'hFFFFF0, 2'd0, 24'h7FFFFF, 3'b010);
        send_exp(24'h000010, 24'h000004, 2'd0, 24'h00000C, 3'b000);
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b0);
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b1);
        chk("status_ovf", 32'(o_status), 32'b010);
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b0);
        chk("status_clr_wins", 32'(o_status), 32'd0);
        drain();

        // reset with two pairs in flight
        send_exp(24'h000100, 24'h000001, 2'd0, 24'h0000FF, 3'b000);
        send_exp(24'h000200, 24'h000001, 2'd0, 24'h0001FF, 3'b000);
        @(negedge clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_quotient", 32'(o_quotient), 32'd0);
        chk("midrst_flags", 32'(o_flags), 32'd0);
        chk("midrst_status", 32'(o_status), 32'd0);
        chk("midrst_count", 32'(o_op_count), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        repeat (4) drive_cycle(1'b0, '0, '0, 2'd0, 1'b0);

        // 17 results wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) send_rand(2'($urandom_range(0, 3)));
        drain();
        chk("cnt4_wrap", 32'(cnt4), 32'd1);
        chk("cnt16_17", 32'(o_op_count), 32'd17);

        // random traffic with random backpressure and clears
        ready_mode = 1;
        rand_clr   = 1'b1;
        for (int i = 0; i < 300; i++) send_rand(2'($urandom_range(0, 3)));
        rand_clr   = 1'b0;
        drain();
        ready_mode = 0;
        repeat (3) drive_cycle(1'b0, '0, '0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
